exu_ctrl: RTL

Execute-stage controller wrapping the single combinational ALU of the NPC core. It accepts decoded uops from the IDU over a valid/ready handshake and holds each uop and its operands in a one-entry execute register that drives the ALU. It captures the ALU result into a one-entry writeback buffer toward the WBU and computes control-flow targets. It also issues a one-cycle redirect to fetch and squashes wrong-path uops.

---
 rtl/exu_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/exu_ctrl.sv
// -----------------------------------------------------------------------------
// liang_pkg / exu_ctrl
//
// Execute-stage controller wrapped around the single combinational ALU.
// A one-entry execute register (E) feeds the ALU. A one-entry writeback
// buffer (W) holds the ALU result for the WBU. Taken control-flow uops raise
// a one-cycle redirect pulse toward fetch. While that pulse is high, the
// wrong-path uop sitting in E is squashed, and so is anything handshaken
// from the IDU in the same cycle.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   idu_valid_i / idu_ready_o         uop handshake from the IDU
//   uop_info_i, rs1_i, rs2_i          decoded uop and its register operands
//   alu_uop_o, alu_rs1_o, alu_rs2_o   execute-register contents to the ALU
//   alu_res_i, alu_jump_i             ALU result and branch-taken flag
//   wbu_valid_o / wbu_ready_i         writeback handshake toward the WBU
//   wbu_res_o, wbu_uop_o              buffered result and uop
//   redirect_valid_o, redirect_pc_o   one-cycle fetch redirect
// -----------------------------------------------------------------------------
package liang_pkg;
    parameter int XLEN = 32;

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_BRANCH = 3'd1,
        FU_JAL    = 3'd2,
        FU_JALR   = 3'd3,
        FU_LSU    = 3'd4,
        FU_CSR    = 3'd5
    } fu_op_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fu_op_t          fu_op;
        logic [3:0]      fu_func;
    } uop_info_t;
endpackage

module exu_ctrl
    import liang_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            idu_valid_i,
    output logic            idu_ready_o,
    input  uop_info_t       uop_info_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] alu_rs1_o,
    output logic [XLEN-1:0] alu_rs2_o,
    output uop_info_t       alu_uop_o,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic            alu_jump_i,
    output logic            wbu_valid_o,
    input  logic            wbu_ready_i,
    output logic [XLEN-1:0] wbu_res_o,
    output uop_info_t       wbu_uop_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    logic            e_valid_q, e_valid_d;
    uop_info_t       e_uop_q, e_uop_d;
    logic [XLEN-1:0] e_rs1_q, e_rs1_d;
    logic [XLEN-1:0] e_rs2_q, e_rs2_d;
    logic            w_valid_q, w_valid_d;
    logic [XLEN-1:0] w_res_q, w_res_d;
    uop_info_t       w_uop_q, w_uop_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    logic            e_adv;
    logic            accept;
    logic            is_jalr;
    logic            ctrl_taken;
    logic [XLEN-1:0] tgt_base;
    logic [XLEN-1:0] tgt_sum;
    logic [XLEN-1:0] tgt_pc;

    // E may only move into W when W is free or draining this cycle. During a
    // redirect pulse the E entry is wrong-path, so it must not advance.
    assign e_adv       = e_valid_q & (~w_valid_q | wbu_ready_i) & ~redir_valid_q;
    // Ready stays high during the pulse so the IDU's wrong-path uop is
    // consumed and discarded rather than left stalled at the interface.
    assign idu_ready_o = ~e_valid_q | e_adv | redir_valid_q;
    assign accept      = idu_valid_i & idu_ready_o & ~redir_valid_q;

    // Target adder is separate from the ALU; JALR uses rs1 as its base and
    // clears bit 0 of the sum.
    assign is_jalr    = (e_uop_q.fu_op == FU_JALR);
    assign tgt_base   = is_jalr ? e_rs1_q : e_uop_q.pc;
    assign tgt_sum    = tgt_base + e_uop_q.imm;
    assign tgt_pc     = is_jalr ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;
    assign ctrl_taken = (e_uop_q.fu_op == FU_JAL) | is_jalr |
                        ((e_uop_q.fu_op == FU_BRANCH) & alu_jump_i);

    always_comb begin
        e_valid_d     = e_valid_q;
        e_uop_d       = e_uop_q;
        e_rs1_d       = e_rs1_q;
        e_rs2_d       = e_rs2_q;
        w_valid_d     = w_valid_q;
        w_res_d       = w_res_q;
        w_uop_d       = w_uop_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;

        // E -> W
        if (e_adv) begin
            w_valid_d = 1'b1;
            w_res_d   = alu_res_i;
            w_uop_d   = e_uop_q;
            e_valid_d = 1'b0;
            if (ctrl_taken) begin
                redir_valid_d = 1'b1;
                redir_pc_d    = tgt_pc;
            end
        end else if (w_valid_q & wbu_ready_i) begin
            w_valid_d = 1'b0;
        end

        // Squash the wrong-path entry left in E during the pulse.
        if (redir_valid_q) begin
            e_valid_d = 1'b0;
        end

        // IDU -> E
        if (accept) begin
            e_valid_d = 1'b1;
            e_uop_d   = uop_info_i;
            e_rs1_d   = rs1_i;
            e_rs2_d   = rs2_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e_valid_q     <= 1'b0;
            e_uop_q       <= '0;
            e_rs1_q       <= '0;
            e_rs2_q       <= '0;
            w_valid_q     <= 1'b0;
            w_res_q       <= '0;
            w_uop_q       <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            e_valid_q     <= e_valid_d;
            e_uop_q       <= e_uop_d;
            e_rs1_q       <= e_rs1_d;
            e_rs2_q       <= e_rs2_d;
            w_valid_q     <= w_valid_d;
            w_res_q       <= w_res_d;
            w_uop_q       <= w_uop_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign alu_rs1_o        = e_rs1_q;
    assign alu_rs2_o        = e_rs2_q;
    assign alu_uop_o        = e_uop_q;
    assign wbu_valid_o      = w_valid_q;
    assign wbu_res_o        = w_res_q;
    assign wbu_uop_o        = w_uop_q;
    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;

endmodule
